// File: rtl/hilo_ctrl.sv
// HI/LO multiply/divide sequencer: the only writer of the HI/LO pair.
// It iterates MULT/MULTU/DIV/DIVU, stalls the pipeline while busy, and emits a one-cycle {hi,lo} write.
module hilo_ctrl #(
    parameter int FAST_MUL = 1,
    parameter int W        = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2:0]     op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [W-1:0]   hi_cur,
    input  logic [W-1:0]   lo_cur,
    input  logic           flush,
    output logic           stall_o,
    output logic           busy,
    output logic           hilo_we,
    output logic [2*W-1:0] hilo_o
);

    // state | meaning
    // IDLE  | waiting for start; start only sampled here
    // MUL   | multiply (1 cycle fast, 32 cycles shift-add)
    // DIV   | restoring divide, one quotient bit per cycle
    // DONE  | one-cycle HI/LO write strobe
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sgn_q, sgn_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [2*W-1:0]   mcand_q, mcand_d;
    logic [W-1:0]     mplier_q, mplier_d;
    logic [W-1:0]     rem_q, rem_d;
    logic [W-1:0]     quo_q, quo_d;
    logic [W-1:0]     dvs_q, dvs_d;
    logic [2*W-1:0]   res_q, res_d;

    logic             accept;
    logic             op_signed;
    logic [W-1:0]     a_abs, b_abs;
    logic [2*W-1:0]   ext_b;
    logic [W:0]       trial;
    logic [W-1:0]     q_fix, r_fix;

    assign accept    = (state_q == IDLE) && start && !flush;
    assign op_signed = !op[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sgn_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sgn_q    <= sgn_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            res_q    <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (op)
                        3'd0, 3'd1: state_d = MUL;
                        3'd2, 3'd3: state_d = DIV;
                        3'd4, 3'd5: state_d = DONE;
                        default:    state_d = IDLE;
                    endcase
                end
            end
            MUL:  if ((FAST_MUL != 0) || (cnt_q == '0)) state_d = DONE;
            DIV:  if (cnt_q == '0) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_comb begin
        busy    = (state_q != IDLE);
        stall_o = ((state_q == IDLE) && start && !op[2]) || (state_q == MUL) || (state_q == DIV);
        hilo_we = (state_q == DONE) && !flush;
        hilo_o  = res_q;
    end

    always_comb begin
        cnt_d    = cnt_q;
        sgn_d    = sgn_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        res_d    = res_q;
        a_abs    = (op_signed && a[W-1]) ? -a : a;
        b_abs    = (op_signed && b[W-1]) ? -b : b;
        ext_b    = sgn_q ? {{W{b_q[W-1]}}, b_q} : {{W{1'b0}}, b_q};
        trial    = {rem_q, quo_q[W-1]} - {1'b0, dvs_q};
        q_fix    = '0;
        r_fix    = '0;

        if (accept) begin
            case (op)
                3'd0, 3'd1, 3'd2, 3'd3: begin
                    cnt_d    = CNT_LAST;
                    sgn_d    = op_signed;
                    a_d      = a;
                    b_d      = b;
                    acc_d    = '0;
                    mcand_d  = op_signed ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
                    mplier_d = b;
                    rem_d    = '0;
                    quo_d    = a_abs;
                    dvs_d    = b_abs;
                end
                3'd4:    res_d = {a, lo_cur};
                3'd5:    res_d = {hi_cur, a};
                default: ;
            endcase
        end else if ((state_q == MUL) && !flush) begin
            if (FAST_MUL != 0) begin
                res_d = mcand_q * ext_b;
            end else begin
                // The signed multiplier's bit 31 carries weight -2^31, so it is subtracted.
                if (mplier_q[0])
                    acc_d = (sgn_q && (cnt_q == '0)) ? acc_q - mcand_q : acc_q + mcand_q;
                mcand_d  = {mcand_q[2*W-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[W-1:1]};
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                else             res_d = acc_d;
            end
        end else if ((state_q == DIV) && !flush) begin
            if (!trial[W]) begin
                rem_d = trial[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b1};
            end else begin
                rem_d = {rem_q[W-2:0], quo_q[W-1]};
                quo_d = {quo_q[W-2:0], 1'b0};
            end
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                q_fix = (sgn_q && (a_q[W-1] ^ b_q[W-1])) ? -quo_d : quo_d;
                r_fix = (sgn_q && a_q[W-1]) ? -rem_d : rem_d;
                res_d = (b_q == '0) ? {a_q, {W{1'b1}}} : {r_fix, q_fix};
            end
        end
    end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Bench for hilo_ctrl: runs both FAST_MUL builds side by side on shared stimulus.
// Expected results come from an arithmetic reference model and a table of known answers.
module tb_hilo_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0, b = '0, hi_cur = '0, lo_cur = '0;
    logic        flush = 1'b0;

    logic        f_stall, f_busy, f_we;
    logic [63:0] f_hilo;
    logic        s_stall, s_busy, s_we;
    logic [63:0] s_hilo;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hilo_ctrl #(.FAST_MUL(1), .W(32)) u_fast (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .hi_cur(hi_cur), .lo_cur(lo_cur), .flush(flush),
        .stall_o(f_stall), .busy(f_busy), .hilo_we(f_we), .hilo_o(f_hilo)
    );

    hilo_ctrl #(.FAST_MUL(0), .W(32)) u_slow (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .hi_cur(hi_cur), .lo_cur(lo_cur), .flush(flush),
        .stall_o(s_stall), .busy(s_busy), .hilo_we(s_we), .hilo_o(s_hilo)
    );

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, y, h, l);
        longint p;
        int     q, r;
        case (o)
            3'd0: begin
                p = longint'($signed(x)) * longint'($signed(y));
                return p;
            end
            3'd1: return {32'b0, x} * {32'b0, y};
            3'd2: begin
                if (y == 0) return {x, 32'hFFFFFFFF};
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                q = $signed(x) / $signed(y);
                r = $signed(x) % $signed(y);
                return {r, q};
            end
            3'd3: begin
                if (y == 0) return {x, 32'hFFFFFFFF};
                return {x % y, x / y};
            end
            3'd4:    return {x, l};
            3'd5:    return {h, x};
            default: return 64'h0;
        endcase
    endfunction

    // Cycle (after the start cycle) in which hilo_we is due; 0 = no write
    function automatic int latency(input logic [2:0] o, input bit fast);
        case (o)
            3'd0, 3'd1: return fast ? 2 : 33;
            3'd2, 3'd3: return 33;
            3'd4, 3'd5: return 1;
            default:    return 0;
        endcase
    endfunction

    // Issue one op in cycle 0, scramble inputs afterwards, observe 40 cycles.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] av, bv, hv, lv,
                          input logic [63:0] exp);
        int f_n = 0, s_n = 0, f_lat = -1, s_lat = -1, f_st = 0, s_st = 0;
        int fl, sl;
        logic [63:0] f_d = '0, s_d = '0;
        fl = latency(o, 1'b1);
        sl = latency(o, 1'b0);
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv; hi_cur = hv; lo_cur = lv;
        #1;
        if (f_stall) f_st++;
        if (s_stall) s_st++;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0; a = $urandom; b = $urandom; hi_cur = $urandom; lo_cur = $urandom;
            #1;
            if (f_stall) f_st++;
            if (s_stall) s_st++;
            if (f_we) begin f_n++; f_lat = c; f_d = f_hilo; end
            if (s_we) begin s_n++; s_lat = c; s_d = s_hilo; end
        end
        check_int({tag, " fast we_count"}, f_n, (fl != 0) ? 1 : 0);
        check_int({tag, " slow we_count"}, s_n, (sl != 0) ? 1 : 0);
        check_int({tag, " fast stall_cycles"}, f_st, (o <= 3) ? fl : 0);
        check_int({tag, " slow stall_cycles"}, s_st, (o <= 3) ? sl : 0);
        if (fl != 0) begin
            check_int({tag, " fast latency"}, f_lat, fl);
            check_int({tag, " slow latency"}, s_lat, sl);
            check64({tag, " fast hilo"}, f_d, exp);
            check64({tag, " slow hilo"}, s_d, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, h, l;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[12];

    initial begin : main
        int n1, n2, f1, f2, s1, s2;
        logic [63:0] fd2, sd2, fd, sd;
        logic [2:0]  ro;
        logic [31:0] ra, rb, rh, rl;

        vecs[0]  = '{3'd3, 32'd100,        32'd7,          32'h0,  32'h0,  {32'd2, 32'd14}};
        vecs[1]  = '{3'd2, 32'hFFFFFFF9,   32'd2,          32'h0,  32'h0,  {32'hFFFFFFFF, 32'hFFFFFFFD}};
        vecs[2]  = '{3'd2, 32'h80000000,   32'hFFFFFFFF,   32'h0,  32'h0,  {32'h0, 32'h80000000}};
        vecs[3]  = '{3'd3, 32'h12345678,   32'h0,          32'h0,  32'h0,  {32'h12345678, 32'hFFFFFFFF}};
        vecs[4]  = '{3'd2, 32'hFFFFFF00,   32'h0,          32'h0,  32'h0,  {32'hFFFFFF00, 32'hFFFFFFFF}};
        vecs[5]  = '{3'd0, 32'hFFFFFFFF,   32'd2,          32'h0,  32'h0,  {32'hFFFFFFFF, 32'hFFFFFFFE}};
        vecs[6]  = '{3'd1, 32'hFFFFFFFF,   32'd2,          32'h0,  32'h0,  {32'h00000001, 32'hFFFFFFFE}};
        vecs[7]  = '{3'd4, 32'h1234,       32'h0,          32'h77, 32'hAB, {32'h1234, 32'hAB}};
        vecs[8]  = '{3'd5, 32'h5678,       32'h0,          32'hCD, 32'h99, {32'hCD, 32'h5678}};
        vecs[9]  = '{3'd0, 32'h80000000,   32'h80000000,   32'h0,  32'h0,  {32'h40000000, 32'h0}};
        vecs[10] = '{3'd2, 32'd7,          32'hFFFFFFFE,   32'h0,  32'h0,  {32'h1, 32'hFFFFFFFD}};
        vecs[11] = '{3'd6, 32'hDEAD,       32'hBEEF,       32'h0,  32'h0,  64'h0};

        // Reset values
        @(negedge clk);
        @(negedge clk);
        #1;
        check_int("rst fast busy", int'(f_busy), 0);
        check_int("rst fast stall", int'(f_stall), 0);
        check_int("rst fast we", int'(f_we), 0);
        check64("rst fast hilo", f_hilo, 64'h0);
        check_int("rst slow busy", int'(s_busy), 0);
        check64("rst slow hilo", s_hilo, 64'h0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].h, vecs[i].l,
                   vecs[i].exp);

        // Flush at DIV iteration 10
        @(negedge clk);
        start = 1'b1; op = 3'd2; a = 32'd1000; b = 32'd3;
        #1;
        n1 = 0; n2 = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            flush = (c == 10);
            #1;
            if (f_we) n1++;
            if (s_we) n2++;
            if (c == 11) begin
                check_int("flush fast busy", int'(f_busy), 0);
                check_int("flush fast stall", int'(f_stall), 0);
                check_int("flush slow busy", int'(s_busy), 0);
                check_int("flush slow stall", int'(s_stall), 0);
            end
        end
        flush = 1'b0;
        check_int("flush fast no_we", n1, 0);
        check_int("flush slow no_we", n2, 0);
        run_op("after_flush", 3'd0, 32'hFFFFFFF0, 32'd3, 32'h0, 32'h0, {32'hFFFFFFFF, 32'hFFFFFFD0});

        // Flush coincident with DONE suppresses the write
        @(negedge clk);
        start = 1'b1; op = 3'd4; a = 32'h1234; lo_cur = 32'hAB;
        @(negedge clk);
        start = 1'b0; flush = 1'b1;
        #1;
        check_int("done_flush fast we", int'(f_we), 0);
        check_int("done_flush slow we", int'(s_we), 0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check_int("done_flush fast busy", int'(f_busy), 0);
        check_int("done_flush fast we2", int'(f_we), 0);

        // Reset mid-DIV
        @(negedge clk);
        start = 1'b1; op = 3'd3; a = 32'd999; b = 32'd4;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_int("midrst fast busy", int'(f_busy), 0);
        check_int("midrst fast stall", int'(f_stall), 0);
        check_int("midrst fast we", int'(f_we), 0);
        check64("midrst fast hilo", f_hilo, 64'h0);
        check_int("midrst slow busy", int'(s_busy), 0);
        check64("midrst slow hilo", s_hilo, 64'h0);
        rst = 1'b0;

        // start held through a DIV: exactly one write
        @(negedge clk);
        start = 1'b1; op = 3'd3; a = 32'd1000; b = 32'd10;
        n1 = 0; n2 = 0; fd = '0; sd = '0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (c == 34) start = 1'b0;
            #1;
            if (f_we) begin n1++; fd = f_hilo; end
            if (s_we) begin n2++; sd = s_hilo; end
        end
        check_int("held fast we_count", n1, 1);
        check_int("held slow we_count", n2, 1);
        check64("held fast hilo", fd, {32'd0, 32'd100});
        check64("held slow hilo", sd, {32'd0, 32'd100});

        // Back-to-back: MULTU issued in the IDLE cycle right after DONE
        @(negedge clk);
        start = 1'b1; op = 3'd3; a = 32'd50; b = 32'd7;
        n1 = 0; n2 = 0; f1 = -1; f2 = -1; s1 = -1; s2 = -1; fd2 = '0; sd2 = '0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            start = (c == 34);
            if (c == 34) begin op = 3'd1; a = 32'd3; b = 32'd5; end
            #1;
            if (f_we) begin n1++; if (n1 == 1) f1 = c; else begin f2 = c; fd2 = f_hilo; end end
            if (s_we) begin n2++; if (n2 == 1) s1 = c; else begin s2 = c; sd2 = s_hilo; end end
        end
        check_int("b2b fast first", f1, 33);
        check_int("b2b fast second", f2, 36);
        check_int("b2b slow second", s2, 67);
        check64("b2b fast hilo", fd2, 64'd15);
        check64("b2b slow hilo", sd2, 64'd15);

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
            rh = $urandom;
            rl = $urandom;
            run_op($sformatf("rnd%0d", i), ro, ra, rb, rh, rl, model(ro, ra, rb, rh, rl));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
